tile_state_engine: RTL
======================

// Module: tile_state_engine
// PURPOSE
// Parametrised board-state engine for an ROWS x COLS minesweeper grid. Holds per-tile
// flagged/revealed bits, serialises flag/reveal requests through a valid/ready handshake,
// performs zero-tile flood-fill reveal by iterative raster sweeps, and tracks win/lose.
// Sits between the cursor/input controller and the display renderer.
// PARAMETERS
// ROWS        8   grid rows (>=2)
// COLS        8   grid columns (>=2)
// NUM_MINES   10  mines on board; win when revealed_count == ROWS*COLS-NUM_MINES
// FLAG_LIMIT  1   1: refuse setting a flag when flag_count == NUM_MINES; 0: unlimited
// Derived: N=ROWS*COLS, RW=$clog2(ROWS), CW=$clog2(COLS), NW=$clog2(N+1); index=row*COLS+col
// PORTS
// clk            in   1   clock
// rst            in   1   asynchronous, active-low reset
// new_game       in   1   sync clear of board state/status; wins over any request
// req_valid      in   1   request present
// req_ready      out  1   high only in IDLE
// req_op         in   1   0=reveal, 1=flag toggle
// req_row        in   RW  target row
// req_col        in   CW  target column
// mines          in   N   mine map, must stay stable for a game
// zero_adj       in   N   1 = tile has zero adjacent mines (non-mine tiles only)
// flagged        out  N   per-tile flag bits
// revealed       out  N   per-tile revealed bits
// flag_count     out  NW  number of set flags
// revealed_count out  NW  number of revealed tiles
// busy           out  1   high during FILL
// done           out  1   1-cycle pulse: request fully processed (incl. ignored)
// won            out  1   sticky until new_game/reset
// lost           out  1   sticky until new_game/reset
// BEHAVIOUR
// - Reset (async) and new_game (sync): flagged=0, revealed=0, counts=0, won=lost=0,
//   done=0, busy=0, state=IDLE. Reset mid-FILL aborts fill immediately.
// - States: IDLE, FILL, OVER. Accept = req_valid & req_ready, sampled at edge T.
// - Out-of-range row/col: no state change; done at T+1.
// - Flag op: if tile revealed -> ignored. Else toggle bit; clearing always allowed;
//   setting refused (no change) when FLAG_LIMIT=1 and flag_count==NUM_MINES.
//   flag_count +/-1 same edge. done at T+1. Stay IDLE.
// - Reveal op: flagged or already revealed -> ignored, done at T+1.
//   Mine -> set revealed bit, lost=1, -> OVER, done at T+1.
//   Safe, zero_adj=0 -> set bit, done at T+1, stay IDLE.
//   Safe, zero_adj=1 -> set bit, -> FILL with idx=0, changed=0, busy=1.
// - FILL: one tile per cycle, idx 0..N-1. Tile idx is revealed if unrevealed, unflagged,
//   not a mine, and any in-grid 8-neighbour is revealed with zero_adj=1 (no edge wrap).
//   Reveal sets changed. At idx=N-1: if changed (incl. this cycle) -> idx=0, changed=0,
//   new sweep; else -> IDLE, busy=0, done next cycle. Min fill = 2 sweeps (2N cycles).
// - revealed_count increments with every set revealed bit (incl. mine, incl. fill).
// - Win check each cycle: revealed_count==N-NUM_MINES and !lost -> won=1, -> OVER
//   (after fill completes, done pulses same cycle as won rises).
// - OVER: req_ready=0; leaves only via new_game or reset. Flags left as-is.
// - new_game coincident with accept: new_game wins, request dropped, no done.
// - Counts never underflow/overflow: flag_count<=N, revealed_count<=N.
// TESTING (ROWS=COLS=4, NUM_MINES=1, mine at index 15, zero_adj=1 for idx 0-9,12,13)
// 1 Reset mid-FILL: reveal (0,0), assert rst 3 cycles later -> all outputs 0, req_ready=1.
// 2 Flag (1,1) twice -> flag_count 1 then 0, flagged[5] toggles, done at T+1 each time.
// 3 Flag (3,3) then flag (2,2) with FLAG_LIMIT=1 -> second refused, flag_count stays 1;
//   reveal (3,3) -> ignored, done, revealed==0.
// 4 Reveal (2,3) (idx 11, non-zero) -> revealed=0x0800, count 1, done T+1, no busy.
// 5 Reveal (0,0) -> busy, fill reveals all idx 0-14, revealed_count=15, won=1, done
//   after final no-change sweep; further req_valid not accepted.
// 6 Reveal (3,3) -> lost=1, revealed[15]=1, OVER; new_game -> all cleared, IDLE.

Source files
------------

// File: rtl/tile_state_engine.sv
// rtl/tile_state_engine.sv - minesweeper board state engine with flag/reveal requests and flood fill
module tile_state_engine #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int NUM_MINES  = 10,
  parameter int FLAG_LIMIT = 1,
  localparam int N  = ROWS * COLS,
  localparam int RW = $clog2(ROWS),
  localparam int CW = $clog2(COLS),
  localparam int NW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          new_game,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_op,
  input  logic [RW-1:0] req_row,
  input  logic [CW-1:0] req_col,
  input  logic [N-1:0]  mines,
  input  logic [N-1:0]  zero_adj,
  output logic [N-1:0]  flagged,
  output logic [N-1:0]  revealed,
  output logic [NW-1:0] flag_count,
  output logic [NW-1:0] revealed_count,
  output logic          busy,
  output logic          done,
  output logic          won,
  output logic          lost
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_OVER} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  flagged_nxt, revealed_nxt;
  logic [NW-1:0] fcnt_nxt, rcnt_nxt;
  logic          won_nxt, lost_nxt, done_nxt;
  logic [IW-1:0] fill_idx, idx_nxt;
  logic [RW-1:0] fill_row, row_nxt;
  logic [CW-1:0] fill_col, col_nxt;
  logic          changed, changed_nxt;

  logic          in_range;
  logic [IW-1:0] ti;
  logic          nbr_zero;
  logic          fill_hit;

  assign in_range = (int'(req_row) < ROWS) && (int'(req_col) < COLS);
  assign ti       = IW'(int'(req_row) * COLS + int'(req_col));

  // any in-grid 8-neighbour of the sweep tile that is revealed and zero-adjacent
  always_comb begin
    int r;
    int c;
    nbr_zero = 1'b0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        r = int'(fill_row) + dr;
        c = int'(fill_col) + dc;
        if (!(dr == 0 && dc == 0) && r >= 0 && r < ROWS && c >= 0 && c < COLS) begin
          if (revealed[IW'(r * COLS + c)] && zero_adj[IW'(r * COLS + c)])
            nbr_zero = 1'b1;
        end
      end
    end
  end

  assign fill_hit = !revealed[fill_idx] && !flagged[fill_idx] && !mines[fill_idx] && nbr_zero;

  // state register; async reset aborts any fill in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // next-state and board update: request handling, raster sweep, win check, new_game override
  always_comb begin
    state_nxt    = state;
    flagged_nxt  = flagged;
    revealed_nxt = revealed;
    fcnt_nxt     = flag_count;
    rcnt_nxt     = revealed_count;
    won_nxt      = won;
    lost_nxt     = lost;
    done_nxt     = 1'b0;
    idx_nxt      = fill_idx;
    row_nxt      = fill_row;
    col_nxt      = fill_col;
    changed_nxt  = changed;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          done_nxt = 1'b1;
          if (in_range) begin
            if (req_op) begin
              if (!revealed[ti]) begin
                if (flagged[ti]) begin
                  flagged_nxt[ti] = 1'b0;
                  fcnt_nxt        = flag_count - NW'(1);
                end else if (!(FLAG_LIMIT != 0 && flag_count == NW'(NUM_MINES))) begin
                  flagged_nxt[ti] = 1'b1;
                  fcnt_nxt        = flag_count + NW'(1);
                end
              end
            end else if (!flagged[ti] && !revealed[ti]) begin
              revealed_nxt[ti] = 1'b1;
              rcnt_nxt         = revealed_count + NW'(1);
              if (mines[ti]) begin
                lost_nxt  = 1'b1;
                state_nxt = S_OVER;
              end else if (zero_adj[ti]) begin
                state_nxt   = S_FILL;
                done_nxt    = 1'b0;
                idx_nxt     = '0;
                row_nxt     = '0;
                col_nxt     = '0;
                changed_nxt = 1'b0;
              end
            end
          end
        end
      end
      S_FILL: begin
        if (fill_hit) begin
          revealed_nxt[fill_idx] = 1'b1;
          rcnt_nxt               = revealed_count + NW'(1);
          changed_nxt            = 1'b1;
        end
        if (fill_idx == IW'(N - 1)) begin
          idx_nxt     = '0;
          row_nxt     = '0;
          col_nxt     = '0;
          changed_nxt = 1'b0;
          if (!(changed || fill_hit)) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end
        end else begin
          idx_nxt = fill_idx + IW'(1);
          if (fill_col == CW'(COLS - 1)) begin
            col_nxt = '0;
            row_nxt = fill_row + RW'(1);
          end else begin
            col_nxt = fill_col + CW'(1);
          end
        end
      end
      default: ;
    endcase
    if (state_nxt == S_IDLE && !lost_nxt && !won && rcnt_nxt == NW'(N - NUM_MINES)) begin
      won_nxt   = 1'b1;
      state_nxt = S_OVER;
    end
    if (new_game) begin
      state_nxt    = S_IDLE;
      flagged_nxt  = '0;
      revealed_nxt = '0;
      fcnt_nxt     = '0;
      rcnt_nxt     = '0;
      won_nxt      = 1'b0;
      lost_nxt     = 1'b0;
      done_nxt     = 1'b0;
      idx_nxt      = '0;
      row_nxt      = '0;
      col_nxt      = '0;
      changed_nxt  = 1'b0;
    end
  end

  // board, counters, status and sweep position registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flagged        <= '0;
      revealed       <= '0;
      flag_count     <= '0;
      revealed_count <= '0;
      won            <= 1'b0;
      lost           <= 1'b0;
      done           <= 1'b0;
      fill_idx       <= '0;
      fill_row       <= '0;
      fill_col       <= '0;
      changed        <= 1'b0;
    end else begin
      flagged        <= flagged_nxt;
      revealed       <= revealed_nxt;
      flag_count     <= fcnt_nxt;
      revealed_count <= rcnt_nxt;
      won            <= won_nxt;
      lost           <= lost_nxt;
      done           <= done_nxt;
      fill_idx       <= idx_nxt;
      fill_row       <= row_nxt;
      fill_col       <= col_nxt;
      changed        <= changed_nxt;
    end
  end

  // handshake and status outputs decoded from state
  always_comb begin
    req_ready = (state == S_IDLE);
    busy      = (state == S_FILL);
  end

endmodule
